fp_addsub_issue: RTL and testbench

Operand issue and result-capture stage placed directly in front of the `add_sub` floating-point adder/subtractor. It accepts tagged operand pairs over a valid/ready handshake and buffers them in a small FIFO. It drives one pair at a time onto `add_sub`'s `A`/`B`/`addsub` inputs and holds them stable for a fixed settle latency. It then captures `out`/`exception` into a tagged result register that is held until the consumer accepts it.

---
 rtl/fp_addsub_issue.sv | 139 +++++++++++++
 tb/tb_fp_addsub_issue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_issue.sv
// Issue/capture stage in front of the add_sub FP unit: buffers tagged operand
// pairs, holds one pair on A/B/addsub for LAT cycles, then latches the result.
module fp_addsub_issue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic             control,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic             addsub,
    input  logic [31:0]      out,
    input  logic             exception,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_exc,
    output logic [TAG_W-1:0] res_tag
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LAT + 1);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             sub;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    op_t              mem [DEPTH];
    op_t              head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    state_t           state, state_nx;
    logic [LW-1:0]    cnt;
    logic [TAG_W-1:0] tag_q;
    logic             push, pop, capture, res_take, has_op;

    // ready comes only from the registered count, never from a same-cycle pop
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign has_op   = (count != '0);
    assign head     = mem[rd_ptr];

    always_ff @(posedge control) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (has_op) state_nx = WAIT;
            WAIT: if (cnt == LW'(1)) state_nx = HOLD;
            HOLD: if (res_valid && res_ready) state_nx = has_op ? WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        res_take = 1'b0;
        case (state)
            IDLE: pop = has_op;
            WAIT: capture = (cnt == LW'(1));
            HOLD: begin
                res_take = res_valid && res_ready;
                pop      = res_take && has_op;
            end
            default: ;
        endcase
    end

    always_ff @(posedge control) begin
        if (push && !reset) mem[wr_ptr] <= '{a: in_a, b: in_b, sub: in_sub, tag: in_tag};
    end

    always_ff @(posedge control) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // operands stay parked on A/B/addsub until the next pop
    always_ff @(posedge control) begin
        if (reset) begin
            A      <= '0;
            B      <= '0;
            addsub <= 1'b0;
            tag_q  <= '0;
            cnt    <= '0;
        end else if (pop) begin
            A      <= head.a;
            B      <= head.b;
            addsub <= head.sub;
            tag_q  <= head.tag;
            cnt    <= LW'(LAT);
        end else if (state == WAIT) begin
            cnt    <= cnt - LW'(1);
        end
    end

    always_ff @(posedge control) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_exc   <= 1'b0;
            res_tag   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= out;
            res_exc   <= exception;
            res_tag   <= tag_q;
        end else if (res_take) begin
            res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_addsub_issue.sv
// Bench for fp_addsub_issue: a stand-in 2-cycle FP adder, a result scoreboard
// fed from observed handshakes, and directed timing checks around it.
module tb_fp_addsub_issue;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;

    logic             control = 1'b0;
    logic             reset   = 1'b1;
    logic             in_valid = 1'b0, in_sub = 1'b0, res_ready = 1'b0;
    logic [31:0]      in_a = '0, in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready, addsub, exception, res_valid, res_exc;
    logic [31:0]      A, B, out, res_data;
    logic [TAG_W-1:0] res_tag;

    int total = 0, bad = 0, nres = 0, cyc = 0;

    typedef struct {
        logic [31:0]      data;
        logic             exc;
        logic [TAG_W-1:0] tag;
    } res_t;
    res_t exp_q[$];
    int   rise_q[$];

    fp_addsub_issue #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .control(control), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .A(A), .B(B), .addsub(addsub),
        .out(out), .exception(exception),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_exc(res_exc), .res_tag(res_tag)
    );

    always #5 control = ~control;
    always_ff @(posedge control) cyc <= cyc + 1;

    // single <-> double conversion (normals and zero) so real arithmetic can act as the adder
    function automatic real s2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == '0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == '0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic s);
        return r2s(s ? s2r(a) - s2r(b) : s2r(a) + s2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // stand-in add_sub: result appears one edge after operands settle (LAT = 2)
    logic [31:0] add_q;
    logic        exc_q;
    always_ff @(posedge control) begin
        add_q <= fadd(A, B, addsub);
        exc_q <= A[0] ^ B[0];
    end
    assign out       = add_q;
    assign exception = exc_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge control);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [TAG_W-1:0] t);
        in_a = a; in_b = b; in_sub = s; in_tag = t; in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge control);
            if (in_ready) break;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        for (int c = 0; c < 300 && nres < n; c++) tick();
        chk("wait_res", 32'(nres >= n), 32'(1));
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && (exp_q.size() != 0 || res_valid); c++) tick();
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    // scoreboard: handshakes seen mid-cycle take effect at the following edge
    logic             prev_stall = 1'b0, prev_rv = 1'b0;
    logic [31:0]      prev_data = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    always @(negedge control) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_rv    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", res_data, prev_data);
                chk("stall_tag", 32'(res_tag), 32'(prev_tag));
            end
            if (res_valid && !prev_rv) rise_q.push_back(cyc);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) chk("res_spurious", 32'(res_valid), 32'(0));
                else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_exc", 32'(res_exc), 32'(e.exc));
                    chk("res_tag", 32'(res_tag), 32'(e.tag));
                end
                nres++;
            end
            if (in_valid && in_ready)
                exp_q.push_back('{fadd(in_a, in_b, in_sub), in_a[0] ^ in_b[0], in_tag});
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_tag   = res_tag;
            prev_rv    = res_valid;
        end
    end

    initial begin
        int base;
        logic [31:0] ya, yb;

        repeat (2) tick();
        reset = 1'b0;
        chk("rst_A", A, 32'h0);
        chk("rst_B", B, 32'h0);
        chk("rst_addsub", 32'(addsub), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_exc", 32'(res_exc), 32'(0));
        chk("rst_res_tag", 32'(res_tag), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // single add: operands after k+1, result visible after k+3 for one cycle
        res_ready = 1'b1;
        push(32'h3E800000, 32'h42C80000, 1'b0, 4'd1);
        chk("one_A_pre", A, 32'h0);
        tick();
        chk("one_A", A, 32'h3E800000);
        chk("one_B", B, 32'h42C80000);
        chk("one_addsub", 32'(addsub), 32'(0));
        tick();
        chk("one_early", 32'(res_valid), 32'(0));
        tick();
        chk("one_valid", 32'(res_valid), 32'(1));
        chk("one_data", res_data, 32'h42C88000);
        chk("one_exc", 32'(res_exc), 32'(0));
        chk("one_tag", 32'(res_tag), 32'(1));
        tick();
        chk("one_pulse", 32'(res_valid), 32'(0));

        // back-to-back spacing
        rise_q.delete();
        base = nres;
        push(32'h3FA00000, 32'h40200000, 1'b0, 4'd2);
        push(32'h42C80000, 32'h43C80000, 1'b0, 4'd3);
        push(32'h3FA00000, 32'h3FA00000, 1'b1, 4'd4);
        wait_res(base + 3);
        chk("b2b_rises", 32'(rise_q.size()), 32'(3));
        if (rise_q.size() >= 3) begin
            chk("b2b_gap1", 32'(rise_q[1] - rise_q[0]), 32'(LAT + 1));
            chk("b2b_gap2", 32'(rise_q[2] - rise_q[1]), 32'(LAT + 1));
        end
        drain();

        // backpressure until the FIFO fills
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(5 + i));
        chk("bp_full", 32'(in_ready), 32'(0));
        chk("bp_hold_valid", 32'(res_valid), 32'(1));
        chk("bp_hold_tag", 32'(res_tag), 32'(5));
        fork
            push(rnd_fp(), rnd_fp(), 1'b0, 4'd10);
            begin
                repeat (3) tick();
                chk("bp_still_full", 32'(in_ready), 32'(0));
                chk("bp_still_tag", 32'(res_tag), 32'(5));
                res_ready = 1'b1;
            end
        join
        drain();

        // pointer wrap with random consumer stalls
        base = nres;
        fork
            for (int i = 0; i < 2 * DEPTH + 1; i++) begin
                push(rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)), 4'(i + 1));
                repeat ($urandom_range(0, 2)) tick();
            end
            for (int c = 0; c < 600 && nres < base + 2 * DEPTH + 1; c++) begin
                res_ready = 1'($urandom_range(0, 1));
                tick();
            end
        join
        res_ready = 1'b1;
        drain();
        chk("wrap_cnt", 32'(nres - base), 32'(2 * DEPTH + 1));

        // reset during WAIT discards the operation
        push(rnd_fp(), rnd_fp(), 1'b0, 4'd11);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(res_valid), 32'(0));
        chk("mid_rst_A", A, 32'h0);
        chk("mid_rst_B", B, 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'(1));
        repeat (4) tick();
        chk("mid_rst_nores", 32'(res_valid), 32'(0));
        push(rnd_fp(), rnd_fp(), 1'b1, 4'd12);
        repeat (2) tick();
        chk("post_rst_early", 32'(res_valid), 32'(0));
        tick();
        chk("post_rst_valid", 32'(res_valid), 32'(1));
        chk("post_rst_tag", 32'(res_tag), 32'(12));
        drain();

        // push on the same edge that empties HOLD: goes via IDLE, one cycle slower
        res_ready = 1'b0;
        push(rnd_fp(), rnd_fp(), 1'b0, 4'd13);
        for (int c = 0; c < 20 && !res_valid; c++) tick();
        chk("corner_hold", 32'(res_valid), 32'(1));
        ya = rnd_fp();
        yb = rnd_fp();
        in_a = ya; in_b = yb; in_sub = 1'b1; in_tag = 4'd14;
        in_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("corner_h0", 32'(res_valid), 32'(0));
        tick();
        chk("corner_pop_A", A, ya);
        chk("corner_h1", 32'(res_valid), 32'(0));
        tick();
        chk("corner_h2", 32'(res_valid), 32'(0));
        tick();
        chk("corner_h3", 32'(res_valid), 32'(1));
        chk("corner_tag", 32'(res_tag), 32'(14));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
